lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/control_types.sv | 10 +
 rtl/lsu_types.sv | 48 ++++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_types.sv
// Shared core-control types.
// mem_op : direction of a data-memory access (READ = load, WRITE = store).
package control_types;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_op;

endpackage

// File: rtl/lsu_types.sv
// Types and helpers for the load/store unit controller.
// lsu_state_e : controller FSM states.
// err_cause_e : encoding of the err_cause output.
// F3_*        : funct3 access-size/sign codes.
// f3_legal / addr_aligned : request screening applied in IDLE.
package lsu_types;

    import control_types::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_FUNCT3   = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } err_cause_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only make sense for loads.
    function automatic logic f3_legal(input mem_op rw, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return (rw == READ);
            default:          return 1'b0;
        endcase
    endfunction

    // funct3[1:0] carries the size for every legal code: 00 byte, 01 half, 10 word.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return ~lo[0];
            2'b10:   return (lo == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU (purely combinational).
// Ports:
//   funct3_i  : access size/sign code of the latched request
//   addr_lo_i : addr[1:0] of the latched request
//   st_data_i : store source value
//   rdata_i   : word returned by memory
//   be_o      : byte enables for stores (and loads)
//   wdata_o   : lane-replicated store data
//   ld_data_o : lane-selected, sign/zero-extended load value
module lsu_align
    import lsu_types::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  rd_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = rdata_i[8*gi +: 8];
            // Byte stores put the low byte on every lane, half stores put the
            // low half on both halves, so memory just honours the enables.
            assign wdata_o[8*gi +: 8] =
                (funct3_i[1:0] == 2'b00) ? st_data_i[7:0] :
                (funct3_i[1:0] == 2'b01) ? st_data_i[8*(gi%2) +: 8] :
                                           st_data_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   be_o = 4'b0001 << addr_lo_i;
            2'b01:   be_o = 4'b0011 << addr_lo_i;
            default: be_o = 4'b1111;
        endcase
    end

    always_comb begin
        byte_sel = rd_lane[addr_lo_i];
        half_sel = {rd_lane[{addr_lo_i[1], 1'b1}], rd_lane[{addr_lo_i[1], 1'b0}]};
        case (funct3_i)
            F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data_o = {24'd0, byte_sel};
            F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data_o = {16'd0, half_sel};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: screens a load/store in IDLE, issues one
// data-memory request, waits for the ack (bounded by TIMEOUT_CYCLES),
// and reports completion or an error for exactly one cycle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   lsu_req, mem_rw     : core requests a load (READ) or store (WRITE)
//   funct3, addr        : access size/sign and byte address
//   st_data             : store source value
//   dmem_*              : data-memory request/response handshake
//   stall               : hold the core while the access is outstanding
//   ld_data, ld_vld     : load writeback value and its one-cycle strobe
//   lsu_err, err_cause  : one-cycle error strobe and its cause
module lsu_ctrl
    import control_types::*;
    import lsu_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req,
    input  mem_op       mem_rw,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_vld,
    output logic        lsu_err,
    output logic [1:0]  err_cause
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [2:0]  f3_q, f3_d;
    mem_op       rw_q, rw_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] ld_data_q, ld_data_d;
    err_cause_e  cause_q, cause_d;

    logic        req_f3_ok;
    logic        req_aligned;
    logic [31:0] cnt_inc;
    logic        timeout_hit;
    logic [3:0]  be_w;
    logic [31:0] wdata_w;
    logic [31:0] ld_ext_w;

    assign req_f3_ok   = f3_legal(mem_rw, funct3);
    assign req_aligned = addr_aligned(funct3, addr[1:0]);
    // The counter holds the number of BUSY cycles already spent, so the
    // cycle in which it would reach the limit is the last one allowed.
    assign cnt_inc     = cnt_q + 32'd1;
    assign timeout_hit = (cnt_inc == 32'(TIMEOUT_CYCLES));

    // Steering works on latched values so the bus stays stable in BUSY.
    lsu_align u_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .st_data_i (sdata_q),
        .rdata_i   (dmem_rdata),
        .be_o      (be_w),
        .wdata_o   (wdata_w),
        .ld_data_o (ld_ext_w)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req) begin
                    state_d = (req_f3_ok && req_aligned) ? ST_BUSY : ST_ERR;
                end
            end
            ST_BUSY: begin
                // An ack in the final allowed cycle still completes normally.
                if (dmem_ack) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        dmem_req   = (state_q == ST_BUSY);
        dmem_we    = (state_q == ST_BUSY) && (rw_q == WRITE);
        dmem_be    = (state_q == ST_BUSY) ? be_w : 4'b0000;
        dmem_addr  = {addr_q[31:2], 2'b00};
        dmem_wdata = wdata_w;
        stall      = lsu_req & ~((state_q == ST_DONE) || (state_q == ST_ERR));
        ld_vld     = (state_q == ST_DONE) && (rw_q == READ);
        lsu_err    = (state_q == ST_ERR);
        err_cause  = (state_q == ST_ERR) ? cause_q : CAUSE_NONE;
        ld_data    = ld_data_q;
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        f3_d      = f3_q;
        rw_d      = rw_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        cause_d   = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req) begin
                    // An illegal funct3 outranks a misaligned address.
                    if (!req_f3_ok) begin
                        cause_d = CAUSE_FUNCT3;
                    end else if (!req_aligned) begin
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        addr_d  = addr;
                        sdata_d = st_data;
                        f3_d    = funct3;
                        rw_d    = mem_rw;
                        cnt_d   = 32'd0;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_inc;
                if (dmem_ack) begin
                    if (rw_q == READ) begin
                        ld_data_d = ld_ext_w;
                    end
                end else if (timeout_hit) begin
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= 32'd0;
            sdata_q   <= 32'd0;
            f3_q      <= 3'd0;
            rw_q      <= READ;
            cnt_q     <= 32'd0;
            ld_data_q <= 32'd0;
            cause_q   <= CAUSE_NONE;
        end else begin
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            f3_q      <= f3_d;
            rw_q      <= rw_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            cause_q   <= cause_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a table of load/store transactions driven through a
// small memory responder, with expected completions queued at issue time
// and checked when the controller finishes, plus hand-written sequences
// for request drop, late ack and reset in the middle of an access.
module tb_lsu_ctrl;
    import control_types::*;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        lsu_req;
    mem_op       mem_rw;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_vld;
    logic        lsu_err;
    logic [1:0]  err_cause;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        mem_op       rw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          dly;
        logic        err;
        logic [1:0]  cause;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        int          busy;
    } vec_t;

    typedef struct {
        logic        err;
        logic [1:0]  cause;
        logic        vld;
        logic [31:0] ld;
        int          busy;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[16];

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lsu_req    (lsu_req),
        .mem_rw     (mem_rw),
        .funct3     (funct3),
        .addr       (addr),
        .st_data    (st_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .stall      (stall),
        .ld_data    (ld_data),
        .ld_vld     (ld_vld),
        .lsu_err    (lsu_err),
        .err_cause  (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // dly = BUSY cycles without ack before the ack cycle; a large dly means no ack.
    function automatic vec_t mk(mem_op rw, logic [2:0] f3, logic [31:0] a, logic [31:0] sd,
                                logic [31:0] rd, int dly, logic err, logic [1:0] cause,
                                logic [3:0] be, logic [31:0] wd, logic [31:0] ld);
        vec_t v;
        v.rw = rw; v.f3 = f3; v.addr = a; v.sd = sd; v.rdata = rd; v.dly = dly;
        v.err = err; v.cause = cause; v.be = be; v.wd = wd; v.ld = ld;
        if (!err)                v.busy = dly + 1;
        else if (cause == 2'b11) v.busy = TO;
        else                     v.busy = 0;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        exp_t e;
        int   busy_seen;
        bit   done;
        e.err   = v.err;
        e.cause = v.cause;
        e.vld   = !v.err && (v.rw == READ);
        e.ld    = v.ld;
        e.busy  = v.busy;
        @(negedge clk);
        lsu_req = 1'b1; mem_rw = v.rw; funct3 = v.f3; addr = v.addr; st_data = v.sd;
        exp_q.push_back(e);
        busy_seen = 0;
        done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk); #1;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (!stall) begin
                done = 1'b1;
                e = exp_q.pop_front();
                $display("txn %s f3=%b addr=%h: err=%0d cause=%0d vld=%0d ld=%h busy=%0d",
                         v.rw == READ ? "LD" : "ST", v.f3, v.addr, lsu_err, err_cause,
                         ld_vld, ld_data, busy_seen);
                chk("lsu_err", 32'(lsu_err), 32'(e.err));
                chk("err_cause", 32'(err_cause), 32'(e.cause));
                chk("ld_vld", 32'(ld_vld), 32'(e.vld));
                chk("ld_data", ld_data, e.ld);
                chk("busy_cycles", 32'(busy_seen), 32'(e.busy));
                chk("latency", 32'(cyc), 32'(e.busy + 1));
            end else if (dmem_req) begin
                busy_seen++;
                chk("dmem_addr", dmem_addr, {v.addr[31:2], 2'b00});
                chk("dmem_be", 32'(dmem_be), 32'(v.be));
                chk("dmem_we", 32'(dmem_we), 32'(v.rw == WRITE));
                if (v.rw == WRITE) chk("dmem_wdata", dmem_wdata, v.wd);
                if (busy_seen == v.dly + 1) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = v.rdata;
                end
            end
        end
        lsu_req = 1'b0;
        if (!done) begin
            void'(exp_q.pop_front());
            chk("completion_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        exp_t e;
        vecs[0]  = mk(READ,  3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 2,  0, 2'b00, 4'b1111, 32'h0,        32'hDEADBEEF);
        vecs[1]  = mk(READ,  3'b000, 32'h103, 32'h0,        32'h80FF0000, 0,  0, 2'b00, 4'b1000, 32'h0,        32'hFFFFFF80);
        vecs[2]  = mk(READ,  3'b100, 32'h103, 32'h0,        32'h80FF0000, 1,  0, 2'b00, 4'b1000, 32'h0,        32'h00000080);
        vecs[3]  = mk(WRITE, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        1,  0, 2'b00, 4'b1100, 32'hABCDABCD, 32'h00000080);
        vecs[4]  = mk(READ,  3'b010, 32'h101, 32'h0,        32'h0,        0,  1, 2'b01, 4'b0000, 32'h0,        32'h00000080);
        vecs[5]  = mk(WRITE, 3'b011, 32'h200, 32'h0,        32'h0,        0,  1, 2'b10, 4'b0000, 32'h0,        32'h00000080);
        vecs[6]  = mk(READ,  3'b001, 32'h102, 32'h0,        32'h80011234, 0,  0, 2'b00, 4'b1100, 32'h0,        32'hFFFF8001);
        vecs[7]  = mk(READ,  3'b101, 32'h102, 32'h0,        32'h80011234, 0,  0, 2'b00, 4'b1100, 32'h0,        32'h00008001);
        vecs[8]  = mk(WRITE, 3'b000, 32'h201, 32'h000000A5, 32'h0,        0,  0, 2'b00, 4'b0010, 32'hA5A5A5A5, 32'h00008001);
        vecs[9]  = mk(WRITE, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        2,  0, 2'b00, 4'b1111, 32'hCAFEF00D, 32'h00008001);
        vecs[10] = mk(READ,  3'b001, 32'h101, 32'h0,        32'h0,        0,  1, 2'b01, 4'b0000, 32'h0,        32'h00008001);
        vecs[11] = mk(READ,  3'b110, 32'h101, 32'h0,        32'h0,        0,  1, 2'b10, 4'b0000, 32'h0,        32'h00008001);
        vecs[12] = mk(WRITE, 3'b100, 32'h204, 32'h0,        32'h0,        0,  1, 2'b10, 4'b0000, 32'h0,        32'h00008001);
        vecs[13] = mk(READ,  3'b000, 32'h100, 32'h0,        32'h0000007F, 0,  0, 2'b00, 4'b0001, 32'h0,        32'h0000007F);
        vecs[14] = mk(READ,  3'b010, 32'h10C, 32'h0,        32'h13579BDF, 3,  0, 2'b00, 4'b1111, 32'h0,        32'h13579BDF);
        vecs[15] = mk(READ,  3'b010, 32'h108, 32'h0,        32'h0,        99, 1, 2'b11, 4'b1111, 32'h0,        32'h13579BDF);

        // Reset values, with a pending request showing through on stall.
        rst_n = 1'b0; lsu_req = 1'b1; mem_rw = READ; funct3 = 3'b010;
        addr = 32'h104; st_data = 32'hFFFFFFFF; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #12;
        $display("reset: stall=%0d req=%0d be=%h addr=%h", stall, dmem_req, dmem_be, dmem_addr);
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_ld_vld", 32'(ld_vld), 32'd0);
        chk("rst_lsu_err", 32'(lsu_err), 32'd0);
        chk("rst_err_cause", 32'(err_cause), 32'd0);
        lsu_req = 1'b0; #1;
        chk("rst_stall_noreq", 32'(stall), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_txn(vecs[i]);

        // Late ack after the timeout must be ignored.
        @(negedge clk); #1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk); #1; dmem_ack = 1'b0;
        $display("late ack: req=%0d vld=%0d ld=%h", dmem_req, ld_vld, ld_data);
        chk("late_ack_vld", 32'(ld_vld), 32'd0);
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_ld", ld_data, 32'h13579BDF);

        // Request drops during BUSY: the load still completes.
        @(negedge clk);
        lsu_req = 1'b1; mem_rw = READ; funct3 = 3'b001; addr = 32'h400;
        e.err = 0; e.cause = 0; e.vld = 1; e.ld = 32'h00005678; e.busy = 2;
        exp_q.push_back(e);
        @(negedge clk); #1;
        chk("drop_busy1_req", 32'(dmem_req), 32'd1);
        lsu_req = 1'b0; #1;
        chk("drop_stall", 32'(stall), 32'd0);
        @(negedge clk); #1;
        chk("drop_busy2_req", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk); #1; dmem_ack = 1'b0;
        e = exp_q.pop_front();
        $display("drop txn: vld=%0d ld=%h", ld_vld, ld_data);
        chk("drop_ld_vld", 32'(ld_vld), 32'(e.vld));
        chk("drop_ld_data", ld_data, e.ld);
        @(negedge clk); #1;
        chk("drop_idle_vld", 32'(ld_vld), 32'd0);
        chk("drop_idle_req", 32'(dmem_req), 32'd0);

        // Reset in the second BUSY cycle.
        @(negedge clk);
        lsu_req = 1'b1; mem_rw = READ; funct3 = 3'b010; addr = 32'h110;
        @(negedge clk); #1;
        chk("rstbusy_req1", 32'(dmem_req), 32'd1);
        @(negedge clk); #1;
        chk("rstbusy_req2", 32'(dmem_req), 32'd1);
        rst_n = 1'b0; #1;
        $display("reset mid-busy: req=%0d ld=%h", dmem_req, ld_data);
        chk("rstbusy_req_drop", 32'(dmem_req), 32'd0);
        chk("rstbusy_ld_data", ld_data, 32'd0);
        lsu_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1; dmem_ack = 1'b1; dmem_rdata = 32'hA5A5A5A5;
        chk("rstbusy_idle_req", 32'(dmem_req), 32'd0);
        @(negedge clk); #1; dmem_ack = 1'b0;
        chk("rstbusy_ack_vld", 32'(ld_vld), 32'd0);
        chk("rstbusy_ack_ld", ld_data, 32'd0);

        // Normal operation resumes after reset.
        run_txn(mk(READ, 3'b010, 32'h0, 32'h0, 32'h55AA33CC, 0, 0, 2'b00, 4'b1111, 32'h0, 32'h55AA33CC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
